// File: rtl/lcd_spi_pkg.sv
// lcd_spi_pkg -- shared types and constants for the LCD serial transmitter (rev 1.0)
`default_nettype none

package lcd_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int   DEFAULT_HALF_PERIOD = 1;
    localparam logic DNC_COMMAND         = 1'b0;
    localparam logic DNC_DATA            = 1'b1;

endpackage

`default_nettype wire

// File: rtl/lcd_tx_buffer.sv
// lcd_tx_buffer -- one-entry holding register for {data, is_data} (rev 1.0)
`default_nettype none

module lcd_tx_buffer
    import lcd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       is_data,
    input  logic       valid,
    input  logic       pop,
    output logic       ready,
    output logic       full,
    output logic [7:0] held_data,
    output logic       held_is_data
);

    // pop is only raised while full, so accept and pop never coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            full         <= 1'b0;
            held_data    <= 8'd0;
            held_is_data <= DNC_COMMAND;
        end else if (valid && !full) begin
            full         <= 1'b1;
            held_data    <= data;
            held_is_data <= is_data;
        end else if (pop) begin
            full         <= 1'b0;
        end
    end

    assign ready = ~full;

endmodule

`default_nettype wire

// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx -- MSB-first serial transmitter for the LCD panel (SCLK/SDIN/DnC/nSCE) (rev 1.0)
`default_nettype none

module lcd_spi_tx
    import lcd_spi_pkg::*;
#(
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       is_data,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       sclk,
    output logic       sdin,
    output logic       dnc,
    output logic       nsce
);

    localparam int                CNT_W    = $clog2(HALF_PERIOD + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       shreg, shreg_n;
    logic             sclk_n, sdin_n, dnc_n, nsce_n, busy_n;
    logic             load;
    logic             cnt_done;
    logic             buf_full;
    logic [7:0]       buf_data;
    logic             buf_is_data;

    lcd_tx_buffer u_buffer (
        .clk          (clk),
        .rst          (rst),
        .data         (data),
        .is_data      (is_data),
        .valid        (valid),
        .pop          (load),
        .ready        (ready),
        .full         (buf_full),
        .held_data    (buf_data),
        .held_is_data (buf_is_data)
    );

    assign cnt_done = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            sclk    <= 1'b0;
            sdin    <= 1'b0;
            dnc     <= DNC_COMMAND;
            nsce    <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            sclk    <= sclk_n;
            sdin    <= sdin_n;
            dnc     <= dnc_n;
            nsce    <= nsce_n;
            busy    <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shreg_n = shreg;
        sclk_n  = sclk;
        sdin_n  = sdin;
        dnc_n   = dnc;
        nsce_n  = nsce;
        load    = 1'b0;

        unique case (state)
            IDLE: begin
                sclk_n = 1'b0;
                sdin_n = 1'b0;
                nsce_n = 1'b1;
                if (buf_full) begin
                    load    = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (cnt_done) begin
                    cnt_n   = '0;
                    sclk_n  = 1'b1;
                    state_n = SHIFT;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            SHIFT: begin
                if (!cnt_done) begin
                    cnt_n = cnt + CNT_ONE;
                end else begin
                    cnt_n = '0;
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n = 1'b0;
                        if (bit_idx != 3'd0) begin
                            bit_n   = bit_idx - 3'd1;
                            shreg_n = {shreg[6:0], 1'b0};
                            sdin_n  = shreg[6];
                        end else if (buf_full) begin
                            // next byte chains into the same frame at bit0's falling edge
                            load = 1'b1;
                        end else begin
                            state_n = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt_done) begin
                    cnt_n   = '0;
                    nsce_n  = 1'b1;
                    sdin_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            shreg_n = buf_data;
            sdin_n  = buf_data[7];
            dnc_n   = buf_is_data;
            nsce_n  = 1'b0;
            bit_n   = 3'd7;
            cnt_n   = '0;
        end

        // registered busy tracks next state and next buffer occupancy
        busy_n = (state_n != IDLE) || (buf_full && !load) || (valid && ready);
    end

endmodule

`default_nettype wire
